acc5x4_stream: RTL and testbench
================================

Name: acc5x4_stream

Overview:
- Sequential accumulator that consumes a stream of 5-bit operands and produces one total per group of COUNT operands.
- Default group is 4, the "add four 5-bit numbers" use case of the adder5x4 lab.
- Sits downstream of the operand source and feeds the result consumer.
- Internally performs the running add: acc + operand, ripple-style, one add per accepted operand.

Parameters:
- WIDTH, 5: operand width in bits.
- COUNT, 4: operands per group; legal range 2..16.
- OUT_W, 7: result width; must be >= WIDTH + ceil(log2(COUNT)), so a group can never overflow (4 x 31 = 124 < 128).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand present on in_data.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  WIDTH  unsigned operand.
- out_valid  output  1  out_sum holds a completed group total.
- out_ready  input  1  consumer takes out_sum this cycle.
- out_sum  output  OUT_W  unsigned group total.
- busy  output  1  high when 1..COUNT-1 operands of the current group have been accepted.

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset, rst_n. While rst_n=0: state=ACCUM, acc=0, cnt=0, out_valid=0, out_sum=0, busy=0, in_ready=0.
- in_ready goes to 1 on the first clk edge after rst_n deasserts.
- Transfers: input transfer = in_valid & in_ready at a rising edge. Output transfer = out_valid & out_ready at a rising edge.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On an input transfer with cnt < COUNT-1: acc <= acc + zero-extended in_data; cnt <= cnt+1.
  - On an input transfer with cnt == COUNT-1: out_sum <= acc + in_data; acc <= 0; cnt <= 0; out_valid <= 1; next state HOLD.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_sum is held stable until the output transfer.
  - On an output transfer: out_valid <= 0; next state ACCUM.
  - No operand is accepted in the same cycle as the output transfer; in_ready returns to 1 the following cycle.
- Latency: out_valid rises on the clock edge that accepts the COUNT-th operand, i.e. it is visible the cycle after that operand is presented.
- Throughput: max one group per COUNT+1 cycles with out_ready held at 1.
- Gaps: in_valid=0 in ACCUM leaves acc and cnt unchanged; gaps of any length are allowed.
- Backpressure: out_ready=0 in HOLD holds indefinitely. in_data and in_valid are ignored while in_ready=0, and the upstream source must hold its operand.
- out_ready in ACCUM is ignored.
- busy = (state==ACCUM) & (cnt != 0).
- Arithmetic: unsigned, modulo 2^OUT_W. No overflow is possible given the OUT_W rule.
- Reset mid-group: the partial acc and cnt are discarded; the next accepted operand starts a new group.
- Reset in HOLD: the pending total is lost and out_valid drops immediately (asynchronously).

Optional Feature:
- Macro: ACC5X4_CLEAR_EN.
- Defined:
  - Adds port clr (input, 1, synchronous abort).
  - clr=1 at a rising edge, in any state: acc <= 0; cnt <= 0; out_valid <= 0; state <= ACCUM.
  - clr has priority over a simultaneous input or output transfer. The operand or result of that cycle is dropped and no transfer completes.
  - in_ready stays combinationally 1 in ACCUM even with clr=1.
- Undefined: no clr port; behaviour exactly as above.

Test Plan:
- Reset, then stream 1,2,3,4 back-to-back with out_ready=1 -> out_valid=1 for one cycle with out_sum=10; in_ready=0 in that cycle; busy=1 after the 1st, 2nd and 3rd accepts.
- Stream 31,31,31,31 -> out_sum=124 (7'b1111100); no wrap.
- Stream 5,0,7,9 with 3 idle cycles between operands, out_ready=0 for 6 cycles after completion -> out_valid and out_sum=21 stable all 6 cycles; in_ready=0; next group 1,1,1,1 -> out_sum=4 (acc correctly cleared).
- Accept 10,20, then pulse rst_n=0 mid-cycle -> outputs zero immediately; after release, stream 2,2,2,2 -> out_sum=8, not 38.
- Assert rst_n=0 while in HOLD with out_sum=10 -> out_valid falls without waiting for clk; no stale result after release.
- With ACC5X4_CLEAR_EN: accept 3,3, then drive clr=1 together with in_valid=1 and in_data=3 -> operand dropped, cnt=0; then 1,2,3,4 -> out_sum=10. Also clr in HOLD with out_ready=1 -> no transfer, out_valid=0 next cycle.

Source files
------------

// File: rtl/acc5x4_stream.sv
// acc5x4_stream: streaming accumulator that sums groups of COUNT unsigned
// WIDTH-bit operands and presents each group total on a valid/ready output.
// Optional feature: define ACC5X4_CLEAR_EN to add a synchronous 'clr' abort
// input that discards the group in progress or the pending total.
module acc5x4_stream #(
    parameter int WIDTH = 5,
    parameter int COUNT = 4,
    parameter int OUT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ACC5X4_CLEAR_EN
    input  logic             clr,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_sum,
    output logic             busy
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] acc_next;
    logic [OUT_W-1:0] sum_reg;
    logic [OUT_W-1:0] sum_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [OUT_W-1:0] operand;
    logic             started;
    logic             in_fire;
    logic             out_fire;
    logic             abort;

`ifdef ACC5X4_CLEAR_EN
    assign abort = clr;
`else
    assign abort = 1'b0;
`endif

    assign operand = OUT_W'(in_data);
    assign out_sum = sum_reg;

    // Hold off in_ready until the first edge after reset has been released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // State register; reset forces ACCUM so out_valid drops immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: running sum, operand count and held group total
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            sum_reg <= '0;
        end else begin
            acc     <= acc_next;
            cnt     <= cnt_next;
            sum_reg <= sum_next;
        end
    end

    // Handshake decode, next-state and datapath update; abort beats any transfer
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        sum_next   = sum_reg;
        in_ready   = started && (state == ACCUM);
        out_valid  = (state == HOLD);
        busy       = (state == ACCUM) && (cnt != '0);
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid && out_ready;

        if (abort) begin
            state_next = ACCUM;
            acc_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_fire) begin
                        if (cnt == LAST) begin
                            sum_next   = acc + operand;
                            acc_next   = '0;
                            cnt_next   = '0;
                            state_next = HOLD;
                        end else begin
                            acc_next = acc + operand;
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_fire) begin
                        state_next = ACCUM;
                    end
                end
                default: begin
                    state_next = ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc5x4_stream.sv
// Testbench for acc5x4_stream: directed operand groups with hand-computed
// totals pushed into a scoreboard queue; a monitor pops and compares on every
// output transfer. Build with ACC5X4_CLEAR_EN defined to cover the clr port.
module tb_acc5x4_stream;

    localparam int WIDTH = 5;
    localparam int COUNT = 4;
    localparam int OUT_W = 7;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_sum;
    logic             busy;

    int checks = 0;
    int passes = 0;
    int expq[$];

    acc5x4_stream #(
        .WIDTH(WIDTH),
        .COUNT(COUNT),
        .OUT_W(OUT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef ACC5X4_CLEAR_EN
        .clr      (clr),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .busy     (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Present one operand and hold it until the DUT accepts it (bounded)
    task automatic applyStimulus(input logic [WIDTH-1:0] d);
        logic rdy;
        int   n;
        rdy = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        in_valid = 1'b0;
        if (!rdy) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (out_valid) checkOutput("drain_timeout", 1, 0);
    endtask

    // Monitor: every output transfer must match the oldest expected total
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready && !clr) begin
                if (expq.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_output: got %0d, expected no output", out_sum);
                end else begin
                    checkOutput("group_sum", int'(out_sum), expq.pop_front());
                end
            end
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("rst_in_ready", int'(in_ready), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_sum", int'(out_sum), 0);
        checkOutput("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_release", int'(in_ready), 1);

        // Group 1,2,3,4 back to back with the consumer always ready
        $display("[TB] group 1,2,3,4");
        out_ready = 1'b1;
        expq.push_back(10);
        applyStimulus(5'd1);
        checkOutput("busy_after_1", int'(busy), 1);
        applyStimulus(5'd2);
        checkOutput("busy_after_2", int'(busy), 1);
        applyStimulus(5'd3);
        checkOutput("busy_after_3", int'(busy), 1);
        applyStimulus(5'd4);
        checkOutput("valid_after_4", int'(out_valid), 1);
        checkOutput("in_ready_in_hold", int'(in_ready), 0);
        checkOutput("busy_in_hold", int'(busy), 0);
        @(posedge clk);
        #1;
        checkOutput("valid_one_cycle", int'(out_valid), 0);
        checkOutput("in_ready_back", int'(in_ready), 1);

        // Maximum operands, no wrap
        $display("[TB] group 31,31,31,31");
        expq.push_back(124);
        for (int i = 0; i < 4; i++) applyStimulus(5'd31);
        waitDrain();

        // Gapped operands then backpressure
        $display("[TB] gapped group 5,0,7,9 with backpressure");
        out_ready = 1'b0;
        expq.push_back(21);
        applyStimulus(5'd5);
        idle(3);
        applyStimulus(5'd0);
        idle(3);
        applyStimulus(5'd7);
        idle(3);
        applyStimulus(5'd9);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", int'(out_valid), 1);
            checkOutput("hold_sum", int'(out_sum), 21);
            checkOutput("hold_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expq.push_back(4);
        for (int i = 0; i < 4; i++) applyStimulus(5'd1);
        waitDrain();

        // Reset mid-group discards the partial sum
        $display("[TB] reset mid-group");
        applyStimulus(5'd10);
        applyStimulus(5'd20);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_in_ready", int'(in_ready), 0);
        checkOutput("midrst_out_sum", int'(out_sum), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expq.push_back(8);
        for (int i = 0; i < 4; i++) applyStimulus(5'd2);
        waitDrain();

        // Reset while holding a total drops out_valid without a clock edge
        $display("[TB] reset in HOLD");
        out_ready = 1'b0;
        applyStimulus(5'd1);
        applyStimulus(5'd2);
        applyStimulus(5'd3);
        applyStimulus(5'd4);
        checkOutput("hold_before_rst_valid", int'(out_valid), 1);
        checkOutput("hold_before_rst_sum", int'(out_sum), 10);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_drop_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("no_stale_valid", int'(out_valid), 0);
        end

`ifdef ACC5X4_CLEAR_EN
        // Clear beats a simultaneous input transfer
        $display("[TB] clr tests");
        applyStimulus(5'd3);
        applyStimulus(5'd3);
        in_valid = 1'b1;
        in_data  = 5'd3;
        clr      = 1'b1;
        #1;
        checkOutput("clr_in_ready_comb", int'(in_ready), 1);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        checkOutput("clr_cnt_zero", int'(busy), 0);
        expq.push_back(10);
        applyStimulus(5'd1);
        applyStimulus(5'd2);
        applyStimulus(5'd3);
        applyStimulus(5'd4);
        waitDrain();

        // Clear beats a simultaneous output transfer
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(5'd5);
        checkOutput("clr_hold_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        clr       = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("clr_hold_dropped", int'(out_valid), 0);
        checkOutput("clr_hold_in_ready", int'(in_ready), 1);
`endif

        idle(2);
        checkOutput("queue_empty", expq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
